// File: rtl/mioc_wand_pulse_rx.sv
// mioc_wand_pulse_rx: receive-side monitor for the open-drain wired-AND line.
// The raw line is synchronised and glitch-filtered into line_q. Each low pulse
// of line_q is timed in clocks, and the width is handed to the host over a
// valid/ready slot. A result that arrives while the slot is still occupied
// is dropped and flagged.
// Optional build macro: MIOC_WAND_STUCK_DET_EN. When it is defined, the block
// raises stuck_lo once the line has been low for STUCK_LIM clocks. When it is
// undefined, stuck_lo is tied to 0.
module mioc_wand_pulse_rx #(
  parameter int FILT_LEN  = 4,
  parameter int CNT_W     = 16,
  parameter int STUCK_LIM = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_in,
  output logic             line_q,
  output logic             fall_p,
  output logic             rise_p,
  output logic [CNT_W-1:0] pw_data,
  output logic             pw_ovf,
  output logic             pw_valid,
  input  logic             pw_ready,
  output logic             drop_p,
  output logic             stuck_lo
);

  localparam int               FC_W    = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] WC_MAX  = '1;
  localparam logic [CNT_W-1:0] WC_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_line_q;
  logic [FC_W-1:0]  r_filt_cnt;
  logic             r_fall_p;
  logic             r_rise_p;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_wcnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_pw_data;
  logic             r_pw_ovf;
  logic             r_pw_valid;
  logic             r_drop_p;

  logic             w_diff;
  logic             w_toggle;
  logic             w_fall;
  logic             w_rise;
  logic             w_xfer;
  logic             w_cap_ok;
  logic             w_wc_sat;
  logic             w_meas_inc;
  logic [CNT_W-1:0] w_wc_inc;

  // The filter counts samples that disagree with line_q. The toggle fires on
  // the edge where the count would reach FILT_LEN, so both edges of the line
  // see the same 2+FILT_LEN latency.
  assign w_diff     = (r_sync2 != r_line_q);
  assign w_toggle   = w_diff && (r_filt_cnt == FC_LAST);
  assign w_fall     = w_toggle && r_line_q;
  assign w_rise     = w_toggle && !r_line_q;
  assign w_xfer     = r_pw_valid && pw_ready;
  assign w_cap_ok   = !r_pw_valid || w_xfer;
  assign w_wc_sat   = (r_wcnt == WC_MAX);
  assign w_wc_inc   = r_wcnt + WC_ONE;
  assign w_meas_inc = (r_state == ST_MEAS) && !w_rise;

  // Two-flop synchroniser. It idles high to match the pull-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= line_in;
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter: line_q changes only after FILT_LEN disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_q   <= 1'b1;
      r_filt_cnt <= '0;
    end else if (!w_diff) begin
      r_filt_cnt <= '0;
    end else if (w_toggle) begin
      r_line_q   <= ~r_line_q;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FC_W'(1);
    end
  end

  // Edge pulses are registered together with line_q, so they mark its first new-level cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall_p <= 1'b0;
      r_rise_p <= 1'b0;
    end else begin
      r_fall_p <= w_fall;
      r_rise_p <= w_rise;
    end
  end

  // Measurement FSM: time the low phase. The counter saturates at all-ones and flags overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_ovf   <= 1'b0;
    end else if (w_fall) begin
      r_state <= ST_MEAS;
      r_wcnt  <= WC_ONE;
      r_ovf   <= 1'b0;
    end else if (w_rise) begin
      r_state <= ST_IDLE;
    end else if (w_meas_inc) begin
      if (w_wc_sat) begin
        r_ovf  <= 1'b1;
      end else begin
        r_wcnt <= w_wc_inc;
      end
    end
  end

  // Result slot: load on rise if empty or draining this cycle; otherwise drop the new width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pw_data  <= '0;
      r_pw_ovf   <= 1'b0;
      r_pw_valid <= 1'b0;
      r_drop_p   <= 1'b0;
    end else begin
      r_drop_p <= 1'b0;
      if (w_rise) begin
        if (w_cap_ok) begin
          r_pw_data  <= r_wcnt;
          r_pw_ovf   <= r_ovf;
          r_pw_valid <= 1'b1;
        end else begin
          r_drop_p   <= 1'b1;
        end
      end else if (w_xfer) begin
        r_pw_valid <= 1'b0;
      end
    end
  end

`ifdef MIOC_WAND_STUCK_DET_EN
  // A limit the counter can never represent must never match its truncated value.
  localparam bit               ST_REACH   = (STUCK_LIM >= 1) &&
                                            (longint'(STUCK_LIM) < (longint'(1) << CNT_W));
  localparam logic [CNT_W-1:0] ST_LIM_V   = CNT_W'(STUCK_LIM);
  localparam bit               ST_AT_FALL = ST_REACH && (STUCK_LIM == 1);

  logic r_stuck_lo;

  // Stuck-low flag: set when the width counter steps onto STUCK_LIM, cleared on the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stuck_lo <= 1'b0;
    end else if (w_rise) begin
      r_stuck_lo <= 1'b0;
    end else if (w_fall) begin
      r_stuck_lo <= ST_AT_FALL;
    end else if (ST_REACH && w_meas_inc && !w_wc_sat && (w_wc_inc == ST_LIM_V)) begin
      r_stuck_lo <= 1'b1;
    end
  end

  assign stuck_lo = r_stuck_lo;
`else
  // STUCK_LIM has no effect in this build; the expression folds to a constant 0.
  assign stuck_lo = 1'b0 & (STUCK_LIM != 0);
`endif

  assign line_q   = r_line_q;
  assign fall_p   = r_fall_p;
  assign rise_p   = r_rise_p;
  assign pw_data  = r_pw_data;
  assign pw_ovf   = r_pw_ovf;
  assign pw_valid = r_pw_valid;
  assign drop_p   = r_drop_p;

endmodule

// File: tb/tb_mioc_wand_pulse_rx.sv
// Bench for mioc_wand_pulse_rx. It runs two instances side by side: a wide
// counter and a 4-bit counter. Both see the same line and ready inputs, and a
// behavioural model of the line and its pulses predicts every output.
module tb_mioc_wand_pulse_rx;

  localparam int FL   = 4;
  localparam int SL_A = 50;
  localparam int SL_B = 12;
`ifdef MIOC_WAND_STUCK_DET_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_in = 1'b1;
  logic pw_ready = 1'b0;

  logic        a_line_q, a_fall_p, a_rise_p, a_pw_ovf, a_pw_valid, a_drop_p, a_stuck_lo;
  logic [15:0] a_pw_data;
  logic        b_line_q, b_fall_p, b_rise_p, b_pw_ovf, b_pw_valid, b_drop_p, b_stuck_lo;
  logic [3:0]  b_pw_data;

  mioc_wand_pulse_rx #(.FILT_LEN(FL), .CNT_W(16), .STUCK_LIM(SL_A)) u_a (
    .clk(clk), .rst_n(rst_n), .line_in(line_in), .line_q(a_line_q),
    .fall_p(a_fall_p), .rise_p(a_rise_p), .pw_data(a_pw_data), .pw_ovf(a_pw_ovf),
    .pw_valid(a_pw_valid), .pw_ready(pw_ready), .drop_p(a_drop_p), .stuck_lo(a_stuck_lo)
  );

  mioc_wand_pulse_rx #(.FILT_LEN(FL), .CNT_W(4), .STUCK_LIM(SL_B)) u_b (
    .clk(clk), .rst_n(rst_n), .line_in(line_in), .line_q(b_line_q),
    .fall_p(b_fall_p), .rise_p(b_rise_p), .pw_data(b_pw_data), .pw_ovf(b_pw_ovf),
    .pw_valid(b_pw_valid), .pw_ready(pw_ready), .drop_p(b_drop_p), .stuck_lo(b_stuck_lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model state.
  bit m_pipe[$];   // line samples still travelling through the synchroniser
  bit m_win[$];    // samples seen by the filter since line_q last changed
  bit m_lq, m_fall, m_rise, m_v, m_drop;
  int m_low;       // true low length, never saturated
  int m_d[2];
  bit m_o[2];
  bit m_stk[2];
  int MAXV[2] = '{65535, 15};
  int SLIM[2] = '{SL_A, SL_B};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe = '{1'b1, 1'b1};
    m_win.delete();
    m_lq = 1'b1; m_fall = 1'b0; m_rise = 1'b0; m_v = 1'b0; m_drop = 1'b0;
    m_low = 0;
    for (int i = 0; i < 2; i++) begin
      m_d[i] = 0; m_o[i] = 1'b0; m_stk[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit li, input bit rdy);
    bit smp, tog, xfer;
    smp = m_pipe.pop_front();
    m_pipe.push_back(li);
    m_win.push_back(smp);
    if (m_win.size() > FL) void'(m_win.pop_front());
    tog = (m_win.size() == FL);
    foreach (m_win[k]) if (m_win[k] == m_lq) tog = 1'b0;
    if (tog) m_win.delete();
    xfer   = m_v && rdy;
    m_fall = tog && m_lq;
    m_rise = tog && !m_lq;
    m_drop = 1'b0;
    if (m_fall) m_low = 1;
    else if (!m_lq && !m_rise) m_low++;
    if (m_rise) begin
      if (!m_v || xfer) begin
        m_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
          m_d[i] = (m_low > MAXV[i]) ? MAXV[i] : m_low;
          m_o[i] = (m_low > MAXV[i]);
        end
      end else begin
        m_drop = 1'b1;
      end
    end else if (xfer) begin
      m_v = 1'b0;
    end
    if (tog) m_lq = !m_lq;
    for (int i = 0; i < 2; i++)
      m_stk[i] = EN && !m_lq && (m_low >= SLIM[i]) && (SLIM[i] <= MAXV[i]);
  endtask

  task automatic check_inst(input string tag, input int i, input logic lq, input logic f,
                            input logic r, input logic v, input logic d, input logic s,
                            input logic [15:0] data, input logic ovf);
    chk({tag, ".line_q"},   lq, m_lq);
    chk({tag, ".fall_p"},   f,  m_fall);
    chk({tag, ".rise_p"},   r,  m_rise);
    chk({tag, ".pw_valid"}, v,  m_v);
    chk({tag, ".drop_p"},   d,  m_drop);
    chk({tag, ".stuck_lo"}, s,  m_stk[i]);
    if (m_v) begin
      chk({tag, ".pw_data"}, data, m_d[i]);
      chk({tag, ".pw_ovf"},  ovf,  m_o[i]);
    end
  endtask

  task automatic check_all();
    check_inst("a", 0, a_line_q, a_fall_p, a_rise_p, a_pw_valid, a_drop_p, a_stuck_lo,
               a_pw_data, a_pw_ovf);
    check_inst("b", 1, b_line_q, b_fall_p, b_rise_p, b_pw_valid, b_drop_p, b_stuck_lo,
               {12'd0, b_pw_data}, b_pw_ovf);
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, then compare.
  task automatic step(input bit li, input bit rdy);
    line_in  = li;
    pw_ready = rdy;
    @(posedge clk);
    model_edge(li, rdy);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      line_in  = 1'($urandom);
      pw_ready = 1'($urandom);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      cyc++;
      check_all();
      chk("rst.line_q", a_line_q, 1'b1);
      chk("rst.pw_valid", a_pw_valid, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, fall_at, rise_at, vcnt, drops, st_first, lowcnt;
    logic [15:0] dat;
    logic ovf, st_rise;
    model_reset();
    @(negedge clk);

    // Reset held while the line toggles.
    do_reset(8);
    repeat (10) step(1'b1, 1'b1);

    // A 3-clock low is shorter than the filter and must vanish.
    fall_at = 0; lowcnt = 0;
    repeat (3) step(1'b0, 1'b1);
    repeat (12) begin
      step(1'b1, 1'b1);
      if (a_fall_p) fall_at++;
      if (!a_line_q) lowcnt++;
    end
    chk("glitch.fall_count", fall_at, 0);
    chk("glitch.low_cycles", lowcnt, 0);
    chk("glitch.pw_valid", a_pw_valid, 1'b0);

    // Clean 20-clock low with ready held high.
    t0 = cyc; fall_at = -1; rise_at = -1; vcnt = 0; dat = '0; ovf = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step((k <= 20) ? 1'b0 : 1'b1, 1'b1);
      if (a_fall_p) fall_at = cyc - t0;
      if (a_rise_p) begin rise_at = cyc - t0; dat = a_pw_data; ovf = a_pw_ovf; end
      if (a_pw_valid) vcnt++;
    end
    chk("p20.fall_at", fall_at, 6);
    chk("p20.rise_at", rise_at, 26);
    chk("p20.pw_data", dat, 20);
    chk("p20.pw_ovf", ovf, 1'b0);
    chk("p20.valid_cycles", vcnt, 1);

    // Two pulses with no consumer: the second one is dropped.
    drops = 0;
    for (int k = 0; k < 65; k++) begin
      step((k < 10) || (k >= 30 && k < 45) ? 1'b0 : 1'b1, 1'b0);
      if (a_drop_p) drops++;
    end
    chk("full.drops", drops, 1);
    chk("full.pw_data", a_pw_data, 10);
    chk("full.pw_valid", a_pw_valid, 1'b1);
    step(1'b1, 1'b1);
    chk("full.valid_after_xfer", a_pw_valid, 1'b0);

    // 30-clock low saturates the 4-bit counter.
    dat = '0; ovf = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step((k < 30) ? 1'b0 : 1'b1, 1'b1);
      if (b_rise_p) begin dat = {12'd0, b_pw_data}; ovf = b_pw_ovf; end
    end
    chk("sat.pw_data", dat, 15);
    chk("sat.pw_ovf", ovf, 1'b1);

    // 60-clock low against STUCK_LIM=50.
    t0 = cyc; st_first = -1; dat = '0; st_rise = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step((k <= 60) ? 1'b0 : 1'b1, 1'b1);
      if (a_stuck_lo && st_first < 0) st_first = cyc - t0;
      if (a_rise_p) begin dat = a_pw_data; st_rise = a_stuck_lo; end
    end
    chk("stuck.first_at", st_first, EN ? 55 : -1);
    chk("stuck.at_rise", st_rise, 1'b0);
    chk("stuck.pw_data", dat, 60);

    // Random segments, random ready, occasional reset in mid-flight.
    for (int seg = 0; seg < 260; seg++) begin
      bit lvl;
      int len, rp;
      lvl = seg[0];
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(4, 30);
      rp  = $urandom_range(0, 3);
      for (int k = 0; k < len; k++)
        step(lvl ? 1'b1 : 1'b0, ($urandom_range(0, 3) < rp) ? 1'b1 : 1'b0);
      if (seg % 70 == 69) begin
        do_reset(2);
        repeat ($urandom_range(2, 12)) step(1'b0, 1'b1);
      end
    end
    repeat (20) step(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
